// File: rtl/seq_magnitude_comparator_pkg.sv
// Shared definitions for the sequential magnitude comparator.
// Contents:
//   state_t - FSM encoding, IDLE -> COMPARE -> DONE -> IDLE
package seq_magnitude_comparator_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COMPARE = 2'd1,
    S_DONE    = 2'd2
  } state_t;

endpackage

// File: rtl/seq_magnitude_comparator_chunk_comparator.sv
// Combinational unsigned comparison of one CHUNK-bit slice.
// Ports:
//   a, b  in  CHUNK  slice of the latched operands
//   lt    out 1      a < b
//   eq    out 1      a == b
//   gt    out 1      a > b
module chunk_comparator
  import seq_magnitude_comparator_pkg::*;
#(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  output logic             lt,
  output logic             eq,
  output logic             gt
);

  assign lt = (a < b);
  assign eq = (a == b);
  assign gt = (a > b);

endmodule

// File: rtl/seq_magnitude_comparator.sv
// Multi-cycle magnitude comparator for wide operands. Walks the latched
// operands MSB-first, CHUNK bits per cycle, and stops at the first chunk
// that differs. Signed compares are done unsigned after flipping the sign
// bit of both operands (offset-binary), which preserves ordering.
// Ports:
//   clk          in   1      rising-edge clock
//   reset        in   1      synchronous, active-high
//   start        in   1      compare request, honoured only when idle
//   signed_mode  in   1      1 = two's complement, 0 = unsigned
//   a, b         in   WIDTH  operands, captured with start
//   busy         out  1      compare in flight (COMPARE or DONE)
//   done         out  1      one-cycle pulse, result valid
//   lt, eq, gt   out  1      result, held until the next accepted start
module seq_magnitude_comparator
  import seq_magnitude_comparator_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             lt,
  output logic             eq,
  output logic             gt
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NCHUNK - 1);
  localparam logic [WIDTH-1:0] MSB_MASK = WIDTH'(1) << (WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             lt_q, lt_d;
  logic             eq_q, eq_d;
  logic             gt_q, gt_d;

  logic             c_lt, c_eq, c_gt;

  chunk_comparator #(
    .CHUNK (CHUNK)
  ) u_chunk (
    .a  (a_q[int'(idx_q) * CHUNK +: CHUNK]),
    .b  (b_q[int'(idx_q) * CHUNK +: CHUNK]),
    .lt (c_lt),
    .eq (c_eq),
    .gt (c_gt)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      idx_q   <= '0;
      lt_q    <= 1'b0;
      eq_q    <= 1'b0;
      gt_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      idx_q   <= idx_d;
      lt_q    <= lt_d;
      eq_q    <= eq_d;
      gt_q    <= gt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    idx_d   = idx_q;
    lt_d    = lt_q;
    eq_d    = eq_q;
    gt_d    = gt_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d     = signed_mode ? (a ^ MSB_MASK) : a;
          b_d     = signed_mode ? (b ^ MSB_MASK) : b;
          idx_d   = IDX_LAST;
          lt_d    = 1'b0;
          eq_d    = 1'b0;
          gt_d    = 1'b0;
          state_d = S_COMPARE;
        end
      end
      S_COMPARE: begin
        if (!c_eq) begin
          lt_d    = c_lt;
          gt_d    = c_gt;
          state_d = S_DONE;
        end else if (idx_q == '0) begin
          eq_d    = 1'b1;
          state_d = S_DONE;
        end else begin
          idx_d = idx_q - IDX_W'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign busy = (state_q != S_IDLE);
  assign done = (state_q == S_DONE);
  assign lt   = lt_q;
  assign eq   = eq_q;
  assign gt   = gt_q;

endmodule

// File: tb/tb_seq_magnitude_comparator.sv
// Directed and model-checked stimulus for seq_magnitude_comparator in three
// shapes: (32,8), (32,32) and (16,1). Latency n counts rising edges after
// the accepting edge until done is visible, which equals k chunks examined.
module tb_seq_magnitude_comparator;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  start, sm, busy, done, lt, eq, gt;
  logic [31:0] a_v [3];
  logic [31:0] b_v [3];
  int          total = 0;
  int          bad   = 0;
  int          cfg_w [3] = '{32, 32, 16};
  int          cfg_c [3] = '{8, 32, 1};

  always #5 clk = ~clk;

  seq_magnitude_comparator #(.WIDTH(32), .CHUNK(8)) u0 (
    .clk(clk), .reset(rst), .start(start[0]), .signed_mode(sm[0]),
    .a(a_v[0]), .b(b_v[0]),
    .busy(busy[0]), .done(done[0]), .lt(lt[0]), .eq(eq[0]), .gt(gt[0]));

  seq_magnitude_comparator #(.WIDTH(32), .CHUNK(32)) u1 (
    .clk(clk), .reset(rst), .start(start[1]), .signed_mode(sm[1]),
    .a(a_v[1]), .b(b_v[1]),
    .busy(busy[1]), .done(done[1]), .lt(lt[1]), .eq(eq[1]), .gt(gt[1]));

  seq_magnitude_comparator #(.WIDTH(16), .CHUNK(1)) u2 (
    .clk(clk), .reset(rst), .start(start[2]), .signed_mode(sm[2]),
    .a(a_v[2][15:0]), .b(b_v[2][15:0]),
    .busy(busy[2]), .done(done[2]), .lt(lt[2]), .eq(eq[2]), .gt(gt[2]));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Launches one compare on DUT c (assumed idle), waits for done, then one
  // more edge so the DUT is idle again on return.
  task automatic run(input int c, input logic [31:0] av, input logic [31:0] bv,
                     input logic m, output logic [2:0] r, output int n,
                     output logic [1:0] post);
    a_v[c] = av; b_v[c] = bv; sm[c] = m; start[c] = 1'b1;
    @(posedge clk); #1;
    start[c] = 1'b0;
    n = 0;
    while (done[c] !== 1'b1 && n < 64) begin
      @(posedge clk); #1;
      n++;
    end
    r = {lt[c], eq[c], gt[c]};
    @(posedge clk); #1;
    post = {busy[c], done[c]};
  endtask

  task automatic directed(input string tag, input int c, input logic [31:0] av,
                          input logic [31:0] bv, input logic m,
                          input logic [2:0] exp_r, input int exp_k);
    logic [2:0] r;
    logic [1:0] post;
    int         n;
    run(c, av, bv, m, r, n, post);
    check({tag, ".res"}, 32'(r), 32'(exp_r));
    check({tag, ".k"}, n, exp_k);
    check({tag, ".idle"}, 32'(post), 32'd0);
  endtask

  // Reference: numeric compare of w-bit values; k from first differing chunk.
  task automatic model(input int w, input int ch, input logic [31:0] av,
                       input logic [31:0] bv, input logic m,
                       output logic [2:0] r, output int k);
    longint ua, ub, sa, sb;
    int     nch;
    logic   found;
    logic [31:0] diff;
    ua = longint'(av) & ((longint'(1) << w) - 1);
    ub = longint'(bv) & ((longint'(1) << w) - 1);
    sa = ua; sb = ub;
    if (m) begin
      if (ua[w-1]) sa = ua - (longint'(1) << w);
      if (ub[w-1]) sb = ub - (longint'(1) << w);
    end
    r = (sa < sb) ? 3'b100 : ((sa == sb) ? 3'b010 : 3'b001);
    nch   = w / ch;
    k     = nch;
    found = 1'b0;
    diff  = av ^ bv;
    for (int i = nch - 1; i >= 0; i--) begin
      if (!found && (((longint'(diff) >> (i * ch)) & ((longint'(1) << ch) - 1)) != 0)) begin
        k     = nch - i;
        found = 1'b1;
      end
    end
  endtask

  initial begin
    logic [2:0]  r, er;
    logic [1:0]  post;
    logic [31:0] av, bv, msk;
    logic        m;
    int          n, ek, idle_cnt, seen;

    rst = 1'b1; start = '0; sm = '0;
    for (int c = 0; c < 3; c++) begin a_v[c] = '0; b_v[c] = '0; end
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int c = 0; c < 3; c++)
      check("reset_state", 32'({busy[c], done[c], lt[c], eq[c], gt[c]}), 32'd0);

    // Directed vectors, (32,8)
    directed("eq_u",      0, 32'h12345678, 32'h12345678, 1'b0, 3'b010, 4);
    directed("msb_u",     0, 32'h80000000, 32'h7FFFFFFF, 1'b0, 3'b001, 1);
    directed("msb_s",     0, 32'h80000000, 32'h7FFFFFFF, 1'b1, 3'b100, 1);
    directed("ff_100_u",  0, 32'h000000FF, 32'h00000100, 1'b0, 3'b100, 3);
    directed("m1_0_s",    0, 32'hFFFFFFFF, 32'h00000000, 1'b1, 3'b100, 1);
    repeat (2) @(posedge clk);
    #1;
    check("hold_result", 32'({lt[0], eq[0], gt[0]}), 32'b100);
    directed("m2_m1_s",   0, 32'hFFFFFFFE, 32'hFFFFFFFF, 1'b1, 3'b100, 4);
    directed("p1_min_s",  0, 32'h00000001, 32'h80000000, 1'b1, 3'b001, 1);

    // Directed vectors, (32,32) and (16,1)
    directed("w_eq",      1, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 3'b010, 1);
    directed("w_u",       1, 32'h80000000, 32'h00000001, 1'b0, 3'b001, 1);
    directed("w_s",       1, 32'h80000000, 32'h00000001, 1'b1, 3'b100, 1);
    directed("b_u",       2, 32'h00008000, 32'h00007FFF, 1'b0, 3'b001, 1);
    directed("b_s",       2, 32'h00008000, 32'h00007FFF, 1'b1, 3'b100, 1);
    directed("b_lsb",     2, 32'h00000001, 32'h00000000, 1'b0, 3'b001, 16);
    directed("b_eq",      2, 32'h0000ABCD, 32'h0000ABCD, 1'b1, 3'b010, 16);

    // Start pulsed mid-compare with new operands must be ignored
    a_v[0] = 32'h12345678; b_v[0] = 32'h12345678; sm[0] = 1'b0; start[0] = 1'b1;
    @(posedge clk); #1;
    start[0] = 1'b0;
    @(posedge clk); #1;
    n = 1;
    a_v[0] = 32'h00000000; b_v[0] = 32'hFFFFFFFF; sm[0] = 1'b1; start[0] = 1'b1;
    @(posedge clk); #1;
    n = 2;
    start[0] = 1'b0;
    while (done[0] !== 1'b1 && n < 64) begin
      @(posedge clk); #1;
      n++;
    end
    check("ignore.k", n, 4);
    check("ignore.res", 32'({lt[0], eq[0], gt[0]}), 32'b010);
    @(posedge clk); #1;

    // Start held high: back-to-back compares, one idle cycle between
    a_v[0] = 32'h01000000; b_v[0] = 32'h02000000; sm[0] = 1'b0; start[0] = 1'b1;
    n = 0;
    while (done[0] !== 1'b1 && n < 64) begin
      @(posedge clk); #1;
      n++;
    end
    check("held.first", 32'({lt[0], eq[0], gt[0]}), 32'b100);
    n = 0; idle_cnt = 0;
    do begin
      @(posedge clk); #1;
      n++;
      if (busy[0] === 1'b0) idle_cnt++;
    end while (done[0] !== 1'b1 && n < 64);
    start[0] = 1'b0;
    check("held.gap", n, 3);
    check("held.idle", idle_cnt, 1);
    check("held.second", 32'({lt[0], eq[0], gt[0]}), 32'b100);
    @(posedge clk); #1;

    // Reset during the second COMPARE cycle aborts the compare
    a_v[0] = 32'h12345678; b_v[0] = 32'h12345678; sm[0] = 1'b0; start[0] = 1'b1;
    @(posedge clk); #1;
    start[0] = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort.outs", 32'({busy[0], done[0], lt[0], eq[0], gt[0]}), 32'd0);
    seen = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (done[0] !== 1'b0) seen++;
    end
    check("abort.nodone", seen, 0);
    directed("post_abort", 0, 32'h00000005, 32'h00000003, 1'b0, 3'b001, 4);

    // Model-checked random operands on each shape
    for (int c = 0; c < 3; c++) begin
      msk = (cfg_w[c] == 32) ? 32'hFFFFFFFF : ((32'd1 << cfg_w[c]) - 32'd1);
      for (int i = 0; i < 1000; i++) begin
        av = $urandom & msk;
        case ($urandom_range(0, 3))
          0:       bv = av;
          1:       bv = av ^ (32'd1 << $urandom_range(0, cfg_w[c] - 1));
          default: bv = $urandom & msk;
        endcase
        m = 1'($urandom_range(0, 1));
        model(cfg_w[c], cfg_c[c], av, bv, m, er, ek);
        run(c, av, bv, m, r, n, post);
        check("rand.res", 32'(r), 32'(er));
        check("rand.k", n, ek);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
